// File: rtl/alu_issue_pkg.sv
// Shared constants for the ALU issue sequencer: ALU opcodes, FSM encoding,
// instruction field positions and the hardwired-zero register index.
package alu_issue_pkg;

    localparam logic [3:0] OP_IDLE = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_NOR  = 4'b0101;
    localparam logic [3:0] OP_AND  = 4'b0110;
    localparam logic [3:0] OP_CBZ  = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b1001;
    localparam logic [3:0] OP_SUB  = 4'b1010;
    localparam logic [3:0] OP_NAND = 4'b1100;
    localparam logic [3:0] OP_MOV  = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WB    = 2'd3
    } issue_state_t;

    localparam int OPC_MSB     = 31;
    localparam int OPC_LSB     = 28;
    localparam int IMM_SEL_BIT = 27;
    localparam int IMM_MSB     = 26;
    localparam int IMM_LSB     = 16;
    localparam int RM_MSB      = 14;
    localparam int RM_LSB      = 10;
    localparam int RN_MSB      = 9;
    localparam int RN_LSB      = 5;
    localparam int RD_MSB      = 4;
    localparam int RD_LSB      = 0;

    localparam int XZR_IDX = 31;

    function automatic logic is_legal(input logic [3:0] op);
        case (op)
            OP_ADD, OP_CBZ, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_NAND, OP_MOV: is_legal = 1'b1;
            default:                         is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// Architectural register file: two async read ports, one sync write port,
// top index hardwired to zero, whole array cleared by reset_n.
module alu_issue_regfile
    import alu_issue_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = XZR_IDX + 1,
    parameter int AW         = $clog2(REG_COUNT)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [AW-1:0]         rd_addr_a,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    input  logic [AW-1:0]         rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_b,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    localparam logic [AW-1:0] ZERO_REG = AW'(REG_COUNT - 1);

    logic [DATA_WIDTH-1:0] regs [REG_COUNT];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != ZERO_REG)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = (rd_addr_a == ZERO_REG) ? '0 : regs[rd_addr_a];
    assign rd_data_b = (rd_addr_b == ZERO_REG) ? '0 : regs[rd_addr_b];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Single-issue sequencer in front of the datapath ALU: decode, operand fetch,
// ALU latency wait, writeback. Define ISSUE_STATS_EN for retire/illegal counters.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | instr_ready high; accept or drop (illegal) one instruction
// ST_ISSUE | drive opcode and operands to the ALU
// ST_WAIT  | hold ALU inputs for ALU_LATENCY edges (down-counter)
// ST_WB    | sample ALU result, pulse done, write register file
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int REG_COUNT   = XZR_IDX + 1,
    parameter int ALU_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [31:0]           instr,
    output logic [DATA_WIDTH-1:0] alu_in_one,
    output logic [DATA_WIDTH-1:0] alu_in_two,
    output logic [3:0]            alu_opcode,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_zero,
    output logic                  done,
    output logic                  wb_en,
    output logic [4:0]            wb_addr,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  branch_taken,
    output logic                  illegal
`ifdef ISSUE_STATS_EN
    ,
    output logic [15:0]           stat_retired,
    output logic [15:0]           stat_illegal
`endif
);

    localparam int AW = $clog2(REG_COUNT);
    localparam logic [4:0] ZERO_REG = 5'(REG_COUNT - 1);

    issue_state_t state, state_nxt;

    logic [3:0]            op_q;
    logic                  imm_sel_q;
    logic [10:0]           imm_q;
    logic [4:0]            rm_q, rn_q, rd_q;
    logic [2:0]            wait_cnt;
    logic                  accept;
    logic                  legal_in;
    logic [DATA_WIDTH-1:0] rf_rd_a, rf_rd_b;
    logic [DATA_WIDTH-1:0] imm_ext;
    logic [DATA_WIDTH-1:0] operand_one, operand_two;
    logic                  unused_instr_bit;

    assign unused_instr_bit = instr[15];
    assign legal_in = is_legal(instr[OPC_MSB:OPC_LSB]);
    assign accept   = (state == ST_IDLE) && instr_valid;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            op_q      <= '0;
            imm_sel_q <= 1'b0;
            imm_q     <= '0;
            rm_q      <= '0;
            rn_q      <= '0;
            rd_q      <= '0;
            wait_cnt  <= '0;
            illegal   <= 1'b0;
        end else begin
            state   <= state_nxt;
            illegal <= accept && !legal_in;
            if (accept && legal_in) begin
                op_q      <= instr[OPC_MSB:OPC_LSB];
                imm_sel_q <= instr[IMM_SEL_BIT];
                imm_q     <= instr[IMM_MSB:IMM_LSB];
                rm_q      <= instr[RM_MSB:RM_LSB];
                rn_q      <= instr[RN_MSB:RN_LSB];
                rd_q      <= instr[RD_MSB:RD_LSB];
            end
            if (state == ST_ISSUE) begin
                wait_cnt <= 3'(ALU_LATENCY - 1);
            end else if ((state == ST_WAIT) && (wait_cnt != '0)) begin
                wait_cnt <= wait_cnt - 3'd1;
            end
        end
    end

    assign imm_ext     = {{(DATA_WIDTH-11){1'b0}}, imm_q};
    // MOV with an immediate routes the constant through inOne, the ALU's pass-through input.
    assign operand_one = (imm_sel_q && (op_q == OP_MOV)) ? imm_ext : rf_rd_a;
    assign operand_two = imm_sel_q ? imm_ext : rf_rd_b;

    always_comb begin
        state_nxt    = state;
        instr_ready  = 1'b0;
        alu_opcode   = OP_IDLE;
        alu_in_one   = '0;
        alu_in_two   = '0;
        done         = 1'b0;
        wb_en        = 1'b0;
        wb_addr      = '0;
        wb_data      = '0;
        branch_taken = 1'b0;
        if (state != ST_IDLE) begin
            alu_opcode = op_q;
            alu_in_one = operand_one;
            alu_in_two = operand_two;
        end
        case (state)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid && legal_in) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (wait_cnt == '0) state_nxt = ST_WB;
            end
            ST_WB: begin
                done         = 1'b1;
                wb_addr      = rd_q;
                wb_data      = alu_result;
                wb_en        = (op_q != OP_CBZ) && (rd_q != ZERO_REG);
                branch_taken = (op_q == OP_CBZ) && alu_zero;
                state_nxt    = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    alu_issue_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_COUNT  (REG_COUNT)
    ) u_regfile (
        .clock     (clock),
        .reset_n   (reset_n),
        .rd_addr_a (rn_q[AW-1:0]),
        .rd_data_a (rf_rd_a),
        .rd_addr_b (rm_q[AW-1:0]),
        .rd_data_b (rf_rd_b),
        .wr_en     (wb_en),
        .wr_addr   (rd_q[AW-1:0]),
        .wr_data   (alu_result)
    );

`ifdef ISSUE_STATS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_retired <= '0;
            stat_illegal <= '0;
        end else begin
            if ((state == ST_WB) && (stat_retired != 16'hFFFF)) stat_retired <= stat_retired + 16'd1;
            if (illegal && (stat_illegal != 16'hFFFF)) stat_illegal <= stat_illegal + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: registered ALU responder, timeline-based
// reference model, per-cycle compare, directed cases and randomized traffic.
module tb_alu_issue_ctrl;

    localparam int DW = 32;
    localparam int L  = 1;

    localparam logic [3:0] ADD = 4'b0010, CBZ = 4'b0111, SUB = 4'b1010, AND_ = 4'b0110,
                           OR_ = 4'b0100, XOR_ = 4'b1001, NOR_ = 4'b0101, NAND_ = 4'b1100,
                           MOV = 4'b1101;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          instr_valid = 1'b0;
    logic [31:0]   instr = '0;
    logic          instr_ready;
    logic [DW-1:0] alu_in_one, alu_in_two;
    logic [3:0]    alu_opcode;
    logic [DW-1:0] alu_result = '0;
    logic          alu_zero = 1'b0;
    logic          done, wb_en, branch_taken, illegal;
    logic [4:0]    wb_addr;
    logic [DW-1:0] wb_data;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    alu_issue_ctrl #(.DATA_WIDTH(DW), .REG_COUNT(32), .ALU_LATENCY(L)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .alu_in_one   (alu_in_one),
        .alu_in_two   (alu_in_two),
        .alu_opcode   (alu_opcode),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .done         (done),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .branch_taken (branch_taken),
        .illegal      (illegal)
    );

    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ADD:     alu_fn = a + b;
            SUB:     alu_fn = a - b;
            AND_:    alu_fn = a & b;
            OR_:     alu_fn = a | b;
            XOR_:    alu_fn = a ^ b;
            NOR_:    alu_fn = ~(a | b);
            NAND_:   alu_fn = ~(a & b);
            MOV:     alu_fn = a;
            CBZ:     alu_fn = a;
            default: alu_fn = '0;
        endcase
    endfunction

    // ALU stand-in with one registered stage
    always @(posedge clock) begin
        alu_result <= alu_fn(alu_opcode, alu_in_one, alu_in_two);
        alu_zero   <= (alu_fn(alu_opcode, alu_in_one, alu_in_two) == 0);
    end

    function automatic logic [31:0] mk(input logic [3:0] op, input logic isel, input logic [10:0] imm,
                                       input logic [4:0] rm, input logic [4:0] rn, input logic [4:0] rd);
        mk = {op, isel, imm, 1'b0, rm, rn, rd};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: timeline of edges; e = edges seen, values valid for the interval after edge e.
    int          e = 0;
    int          acc_edge = -100;
    int          ill_edge = -100;
    logic [31:0] mreg [32];
    logic [3:0]  m_op;
    logic [31:0] m_a, m_b, m_data;
    logic        m_wen, m_br;
    logic [4:0]  m_addr;

    function automatic logic [31:0] rr(input logic [4:0] i);
        rr = (i == 5'd31) ? 32'd0 : mreg[i];
    endfunction

    function automatic logic legal(input logic [3:0] op);
        legal = (op == ADD) || (op == CBZ) || (op == SUB) || (op == AND_) || (op == OR_) ||
                (op == XOR_) || (op == NOR_) || (op == NAND_) || (op == MOV);
    endfunction

    task automatic model_clear();
        acc_edge = -100;
        ill_edge = -100;
        for (int i = 0; i < 32; i++) mreg[i] = '0;
    endtask

    always @(negedge reset_n) model_clear();

    always @(posedge clock) begin : model
        int          ne;
        logic [3:0]  op;
        logic [31:0] imm;
        ne = e + 1;
        if (!reset_n) begin
            model_clear();
        end else if (instr_valid && (e >= acc_edge + 2 + L)) begin
            op  = instr[31:28];
            imm = {21'd0, instr[26:16]};
            if (!legal(op)) begin
                ill_edge = ne;
            end else begin
                m_op   = op;
                m_a    = (op == MOV && instr[27]) ? imm : rr(instr[9:5]);
                m_b    = instr[27] ? imm : rr(instr[14:10]);
                m_data = alu_fn(op, m_a, m_b);
                m_addr = instr[4:0];
                m_wen  = (op != CBZ) && (instr[4:0] != 5'd31);
                m_br   = (op == CBZ) && (rr(instr[9:5]) == 0);
                if (m_wen) mreg[instr[4:0]] = m_data;
                acc_edge = ne;
            end
        end
        e = ne;
    end

    always @(negedge clock) begin
        chk("ready", instr_ready, (e >= acc_edge + 2 + L));
        chk("opcode", alu_opcode, (e >= acc_edge && e <= acc_edge + 1 + L) ? m_op : 4'd0);
        chk("illegal", illegal, (e == ill_edge));
        if (e >= acc_edge && e <= acc_edge + L) begin
            chk("in_one", alu_in_one, m_a);
            chk("in_two", alu_in_two, m_b);
        end
        if (e == acc_edge + 1 + L) begin
            chk("done", done, 1);
            chk("wb_en", wb_en, m_wen);
            chk("wb_addr", wb_addr, m_addr);
            chk("wb_data", wb_data, m_data);
            chk("branch", branch_taken, m_br);
        end else begin
            chk("done_idle", done, 0);
            chk("wb_en_idle", wb_en, 0);
            chk("branch_idle", branch_taken, 0);
        end
    end

    logic        c_wen, c_br;
    logic [4:0]  c_addr;
    logic [31:0] c_data;

    task automatic send(input logic [31:0] ins, input bit hold, input bit wait_done);
        bit rdy, acc, got;
        int lat;
        @(negedge clock);
        #1;
        instr = ins;
        instr_valid = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 64; k++) begin
            rdy = instr_ready;
            @(negedge clock);
            if (rdy) begin
                acc = 1'b1;
                break;
            end
            #1;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=no_accept required=accept instr=%h", ins);
        end
        if (!hold) begin
            #1;
            instr_valid = 1'b0;
        end
        if (wait_done && acc) begin
            got = 1'b0;
            lat = 0;
            for (int k = 1; k <= 20; k++) begin
                @(negedge clock);
                if (done) begin
                    got = 1'b1;
                    lat = k;
                    c_wen = wb_en; c_br = branch_taken; c_addr = wb_addr; c_data = wb_data;
                    break;
                end
            end
            if (!got) begin
                checks++;
                errors++;
                $display("FAIL done_timeout actual=no_done required=done instr=%h", ins);
            end else begin
                chk("latency", lat, 1 + L);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  rop;
        logic [4:0]  rsel [4];
        int          pick;

        repeat (2) @(negedge clock);
        chk("rst_ready", instr_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_opcode", alu_opcode, 0);
        chk("rst_illegal", illegal, 0);
        #1 reset_n = 1'b1;

        // 1: MOV/MOV/ADD
        send(mk(MOV, 1, 11'd15, 0, 0, 1), 0, 1);
        chk("mov_x1", c_data, 32'd15);
        send(mk(MOV, 1, 11'd15, 0, 0, 2), 0, 1);
        send(mk(ADD, 0, 0, 2, 1, 3), 0, 1);
        chk("add_addr", c_addr, 5'd3);
        chk("add_data", c_data, 32'd30);
        chk("add_wen", c_wen, 1);

        // 2: SUB wraps
        send(mk(MOV, 1, 11'd5, 0, 0, 4), 0, 1);
        send(mk(SUB, 0, 0, 2, 4, 5), 0, 1);
        chk("sub_wrap", c_data, 32'hFFFF_FFF6);

        // 3: CBZ
        send(mk(CBZ, 0, 0, 0, 31, 0), 0, 1);
        chk("cbz_zero_wen", c_wen, 0);
        chk("cbz_zero_br", c_br, 1);
        send(mk(CBZ, 0, 0, 0, 1, 0), 0, 1);
        chk("cbz_nz_br", c_br, 0);
        send(mk(ADD, 0, 0, 31, 1, 10), 0, 1);
        chk("x1_kept", c_data, 32'd15);

        // 4: logic ops on X4=5, X6=10
        send(mk(MOV, 1, 11'd10, 0, 0, 6), 0, 1);
        send(mk(AND_, 0, 0, 6, 4, 11), 0, 1);
        chk("and", c_data, 32'd0);
        send(mk(OR_, 0, 0, 6, 4, 11), 0, 1);
        chk("or", c_data, 32'd15);
        send(mk(XOR_, 0, 0, 6, 4, 11), 0, 1);
        chk("xor", c_data, 32'd15);
        send(mk(NOR_, 0, 0, 6, 4, 11), 0, 1);
        chk("nor", c_data, 32'hFFFF_FFF0);
        send(mk(NAND_, 0, 0, 6, 4, 11), 0, 1);
        chk("nand", c_data, 32'hFFFF_FFFF);

        // 5: illegal opcode dropped
        send(mk(4'b1111, 0, 0, 2, 1, 12), 0, 0);
        chk("illegal_pulse", illegal, 1);
        chk("illegal_ready", instr_ready, 1);
        send(mk(ADD, 0, 0, 6, 4, 12), 0, 1);
        chk("after_illegal", c_data, 32'd15);

        // 6: reset in WAIT, then held valid across WB
        send(mk(ADD, 0, 0, 2, 1, 7), 0, 0);
        @(negedge clock);
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        chk("post_rst_ready", instr_ready, 1);
        send(mk(MOV, 0, 0, 0, 7, 8), 0, 1);
        chk("x7_cleared", c_data, 32'd0);

        send(mk(MOV, 1, 11'd9, 0, 0, 9), 1, 0);
        repeat (L + 1) @(negedge clock);
        chk("hold_wb_done", done, 1);
        chk("hold_wb_ready", instr_ready, 0);
        @(negedge clock);
        chk("hold_idle_ready", instr_ready, 1);
        #1 instr_valid = 1'b0;
        repeat (6) @(negedge clock);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            pick = $urandom_range(0, 11);
            case (pick)
                0: rop = ADD;  1: rop = CBZ;  2: rop = SUB;  3: rop = AND_;
                4: rop = OR_;  5: rop = XOR_; 6: rop = NOR_; 7: rop = NAND_;
                8, 9: rop = MOV;
                default: rop = 4'($urandom_range(0, 15));
            endcase
            for (int j = 0; j < 3; j++) begin
                pick = $urandom_range(0, 8);
                rsel[j] = (pick == 8) ? 5'd31 : 5'(pick);
            end
            send(mk(rop, 1'($urandom_range(0, 1)), 11'($urandom), rsel[0], rsel[1], rsel[2]), 0, 0);
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end
        repeat (10) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
